// File: rtl/reg_scoreboard.sv
// reg_scoreboard: register-hazard scoreboard between decode and writeback.
//
// Tracks how many writes are in flight for each architectural register
// (r1..r31; r0 is hard-wired zero and never tracked) and stalls decode while
// a source operand still has a pending write or while issuing would overflow
// a per-register counter or the global in-flight budget.
//
// Ports:
//   clk          clock, all state updates on posedge
//   rst          synchronous active-high reset
//   issue_valid  decode presents an instruction this cycle
//   issue_write  that instruction writes a register
//   issue_waddr  destination register of the issuing instruction
//   rs_addr      source register 1 read by decode
//   rt_addr      source register 2 read by decode
//   rs_used      instruction reads rs
//   rt_used      instruction reads rt
//   wb_valid     writeback stage writes the register file this cycle
//   wb_waddr     writeback destination register
//   stall        decode must hold; issue is not accepted
//   inflight     total pending writes across all registers
//   err          sticky: writeback retired a register with zero pending count
//
// Build option:
//   WB_BYPASS_EN  when defined, a source whose only pending write is retiring
//                 this cycle is not a hazard (decode forwards the writeback
//                 data). Counter behaviour is identical in both builds.

module reg_scoreboard #(
  parameter int unsigned CNT_W        = 2,
  parameter int unsigned MAX_INFLIGHT = 4
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              issue_valid,
  input  logic                              issue_write,
  input  logic [4:0]                        issue_waddr,
  input  logic [4:0]                        rs_addr,
  input  logic [4:0]                        rt_addr,
  input  logic                              rs_used,
  input  logic                              rt_used,
  input  logic                              wb_valid,
  input  logic [4:0]                        wb_waddr,
  output logic                              stall,
  output logic [$clog2(MAX_INFLIGHT+1)-1:0] inflight,
  output logic                              err
);

  localparam int unsigned InflW = $clog2(MAX_INFLIGHT + 1);

  localparam logic [CNT_W-1:0] CntMax  = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CntOne  = CNT_W'(1);
  localparam logic [InflW-1:0] InflMax = InflW'(MAX_INFLIGHT);
  localparam logic [InflW-1:0] InflOne = InflW'(1);

  // Per-register pending counters for r1..r31.
  logic [CNT_W-1:0] pend_q [1:31];
  logic [CNT_W-1:0] pend_d [1:31];
  logic [InflW-1:0] inflight_q, inflight_d;
  logic             err_q, err_d;

  // Read view with r0 constantly zero, so any 5-bit address can index it.
  logic [CNT_W-1:0] pend_rd [32];

  always_comb begin
    pend_rd[0] = '0;
    for (int r = 1; r < 32; r++) begin
      pend_rd[r] = pend_q[r];
    end
  end

  logic [CNT_W-1:0] rs_pend, rt_pend, iw_pend, wb_pend;

  assign rs_pend = pend_rd[rs_addr];
  assign rt_pend = pend_rd[rt_addr];
  assign iw_pend = pend_rd[issue_waddr];
  assign wb_pend = pend_rd[wb_waddr];

  logic track, retire, retire_ok;

  assign track     = issue_valid && issue_write && (issue_waddr != 5'd0);
  assign retire    = wb_valid && (wb_waddr != 5'd0);
  // Only a retire with something pending changes the counters.
  assign retire_ok = retire && (wb_pend != '0);

  // Source forwarding: only the last pending write may be bypassed, since an
  // older retire does not produce the value decode actually needs.
  logic rs_fwd, rt_fwd;

`ifdef WB_BYPASS_EN
  assign rs_fwd = retire && (wb_waddr == rs_addr) && (rs_pend == CntOne);
  assign rt_fwd = retire && (wb_waddr == rt_addr) && (rt_pend == CntOne);
`else
  assign rs_fwd = 1'b0;
  assign rt_fwd = 1'b0;
`endif

  logic src_hazard, cap_hazard, reg_full, infl_full, accept;

  assign src_hazard = (rs_used && (rs_addr != 5'd0) && (rs_pend != '0) && !rs_fwd) ||
                      (rt_used && (rt_addr != 5'd0) && (rt_pend != '0) && !rt_fwd);

  // A legal retire in the same cycle frees the slot the issue would need.
  assign reg_full  = (iw_pend == CntMax) && !(retire_ok && (wb_waddr == issue_waddr));
  assign infl_full = (inflight_q == InflMax) && !retire_ok;

  assign cap_hazard = track && (reg_full || infl_full);
  assign stall      = issue_valid && (src_hazard || cap_hazard);
  assign accept     = track && !stall;

  always_comb begin
    logic inc, dec;
    inc = 1'b0;
    dec = 1'b0;
    for (int r = 1; r < 32; r++) begin
      inc = accept && (issue_waddr == 5'(r));
      dec = retire_ok && (wb_waddr == 5'(r));
      if (inc && !dec) begin
        pend_d[r] = pend_q[r] + CntOne;
      end else if (dec && !inc) begin
        pend_d[r] = pend_q[r] - CntOne;
      end else begin
        pend_d[r] = pend_q[r];
      end
    end

    inflight_d = inflight_q;
    if (accept && !retire_ok) begin
      inflight_d = inflight_q + InflOne;
    end else if (retire_ok && !accept) begin
      inflight_d = inflight_q - InflOne;
    end

    err_d = err_q || (retire && !retire_ok);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int r = 1; r < 32; r++) begin
        pend_q[r] <= '0;
      end
      inflight_q <= '0;
      err_q      <= 1'b0;
    end else begin
      for (int r = 1; r < 32; r++) begin
        pend_q[r] <= pend_d[r];
      end
      inflight_q <= inflight_d;
      err_q      <= err_d;
    end
  end

  assign inflight = inflight_q;
  assign err      = err_q;

endmodule

// File: tb/tb_reg_scoreboard.sv
// Self-checking bench for reg_scoreboard (CNT_W=2, MAX_INFLIGHT=4).
// Each driven cycle pushes the expected stall for that cycle and the expected
// inflight/err after the following edge; a negedge monitor pops and compares.

module tb_reg_scoreboard;

  logic       clk = 1'b0;
  logic       rst;
  logic       issue_valid, issue_write;
  logic [4:0] issue_waddr, rs_addr, rt_addr, wb_waddr;
  logic       rs_used, rt_used, wb_valid;
  logic       stall, err;
  logic [2:0] inflight;

  always #5 clk = ~clk;

  reg_scoreboard #(
    .CNT_W       (2),
    .MAX_INFLIGHT(4)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .issue_valid(issue_valid),
    .issue_write(issue_write),
    .issue_waddr(issue_waddr),
    .rs_addr    (rs_addr),
    .rt_addr    (rt_addr),
    .rs_used    (rs_used),
    .rt_used    (rt_used),
    .wb_valid   (wb_valid),
    .wb_waddr   (wb_waddr),
    .stall      (stall),
    .inflight   (inflight),
    .err        (err)
  );

  typedef struct {
    int    due;
    string tag;
    int    sel;  // 0 stall, 1 inflight, 2 err
    int    exp;
  } exp_t;

  exp_t sb_q[$];
  int   cyc_cnt   = 0;
  int   n_checks  = 0;
  int   n_errors  = 0;
  int   exp_err   = 0;
  int   byp_stall;

  always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  always @(negedge clk) begin : monitor
    exp_t e;
    while (sb_q.size() > 0 && sb_q[0].due <= cyc_cnt) begin
      e = sb_q.pop_front();
      case (e.sel)
        0:       check({e.tag, ".stall"}, 32'(stall), 32'(e.exp));
        1:       check({e.tag, ".inflight"}, 32'(inflight), 32'(e.exp));
        default: check({e.tag, ".err"}, 32'(err), 32'(e.exp));
      endcase
    end
  end

  task automatic push(input int due, input string tag, input int sel, input int exp);
    exp_t e;
    e.due = due;
    e.tag = tag;
    e.sel = sel;
    e.exp = exp;
    sb_q.push_back(e);
  endtask

  // Inputs are already set; record expectations and advance one cycle.
  task automatic step(input string tag, input int es, input int ei);
    push(cyc_cnt, tag, 0, es);
    push(cyc_cnt + 1, tag, 1, ei);
    push(cyc_cnt + 1, tag, 2, exp_err);
    @(posedge clk);
    #1;
  endtask

  task automatic clr();
    rst         = 1'b0;
    issue_valid = 1'b0;
    issue_write = 1'b0;
    issue_waddr = 5'd0;
    rs_addr     = 5'd0;
    rt_addr     = 5'd0;
    rs_used     = 1'b0;
    rt_used     = 1'b0;
    wb_valid    = 1'b0;
    wb_waddr    = 5'd0;
  endtask

  task automatic wr(input string tag, input logic [4:0] wa, input int es, input int ei);
    clr();
    issue_valid = 1'b1;
    issue_write = 1'b1;
    issue_waddr = wa;
    step(tag, es, ei);
  endtask

  task automatic rd_rs(input string tag, input logic [4:0] ra, input int es, input int ei);
    clr();
    issue_valid = 1'b1;
    rs_addr     = ra;
    rs_used     = 1'b1;
    step(tag, es, ei);
  endtask

  task automatic ret(input string tag, input logic [4:0] wa, input int ei);
    clr();
    wb_valid = 1'b1;
    wb_waddr = wa;
    step(tag, 0, ei);
  endtask

  initial begin
`ifdef WB_BYPASS_EN
    byp_stall = 0;
`else
    byp_stall = 1;
`endif
    clr();
    rst = 1'b1;
    @(posedge clk);
    #1;

    // Reset then idle.
    clr(); rst = 1'b1; step("rst0", 0, 0);
    clr(); rst = 1'b1; step("rst1", 0, 0);
    clr(); step("idle", 0, 0);

    // RAW hazard on r5 through rs, then through rt.
    wr("raw_wr5", 5'd5, 0, 1);
    rd_rs("raw_rd5", 5'd5, 1, 1);
    clr(); issue_valid = 1'b1; rs_addr = 5'd5; rs_used = 1'b1;
    wb_valid = 1'b1; wb_waddr = 5'd5;
    step("raw_ret5", byp_stall, 0);
    rd_rs("raw_after", 5'd5, 0, 0);
    wr("raw_wr5b", 5'd5, 0, 1);
    clr(); issue_valid = 1'b1; rs_addr = 5'd5; rs_used = 1'b0;
    step("rs_unused", 0, 1);
    clr(); issue_valid = 1'b1; rt_addr = 5'd5; rt_used = 1'b1;
    step("rt_haz", 1, 1);
    clr(); rs_addr = 5'd5; rs_used = 1'b1;
    step("novalid", 0, 1);
    ret("ret5", 5'd5, 0);

    // Register 0 is never tracked.
    wr("r0_wr", 5'd0, 0, 0);
    rd_rs("r0_rd", 5'd0, 0, 0);
    ret("r0_ret", 5'd0, 0);

    // Global capacity, released by a same-cycle retire.
    wr("cap_wr1", 5'd1, 0, 1);
    wr("cap_wr2", 5'd2, 0, 2);
    wr("cap_wr3", 5'd3, 0, 3);
    wr("cap_wr4", 5'd4, 0, 4);
    wr("cap_wr6", 5'd6, 1, 4);
    clr(); issue_valid = 1'b1; issue_write = 1'b1; issue_waddr = 5'd6;
    wb_valid = 1'b1; wb_waddr = 5'd1;
    step("cap_wr6_ret1", 0, 4);
    rd_rs("cap_rd6", 5'd6, 1, 4);
    rd_rs("cap_rd1", 5'd1, 0, 4);
    ret("cap_ret2", 5'd2, 3);
    ret("cap_ret3", 5'd3, 2);
    ret("cap_ret4", 5'd4, 1);
    ret("cap_ret6", 5'd6, 0);

    // Per-register cap on r7, released by a same-cycle retire of r7.
    wr("pc_wr7a", 5'd7, 0, 1);
    wr("pc_wr7b", 5'd7, 0, 2);
    wr("pc_wr7c", 5'd7, 0, 3);
    wr("pc_wr7d", 5'd7, 1, 3);
    clr(); issue_valid = 1'b1; issue_write = 1'b1; issue_waddr = 5'd7;
    wb_valid = 1'b1; wb_waddr = 5'd7;
    step("pc_wr7_ret7", 0, 3);
    wr("pc_wr7e", 5'd7, 1, 3);
    wr("pc_wr8", 5'd8, 0, 4);
    wr("pc_wr9", 5'd9, 1, 4);
    ret("pc_ret7a", 5'd7, 3);
    ret("pc_ret7b", 5'd7, 2);
    // One write left on r7: the hazard holds until it retires.
    rd_rs("pc_rd7", 5'd7, 1, 2);
    ret("pc_ret7c", 5'd7, 1);
    ret("pc_ret8", 5'd8, 0);

    // Underflow sets sticky err without touching counters.
    exp_err = 1;
    ret("uf_ret9", 5'd9, 0);
    clr(); step("uf_idle", 0, 0);
    wr("uf_wr10", 5'd10, 0, 1);
    rd_rs("uf_rd10", 5'd10, 1, 1);

    // Reset mid-operation clears err and pending state.
    exp_err = 0;
    clr(); rst = 1'b1; step("rst_mid", 0, 0);
    rd_rs("post_rst_rd10", 5'd10, 0, 0);
    clr(); step("final_idle", 0, 0);

    for (int i = 0; i < 5 && sb_q.size() > 0; i++) begin
      @(posedge clk);
    end
    if (sb_q.size() > 0) begin
      n_errors++;
      $display("FAIL drain: got %0d pending, expected 0", sb_q.size());
    end
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
